// File: rtl/rpsc_interlock_card.sv
// RF permit interlock card: per-channel fault filtering, sticky latching and a
// TRIPPED/HOLDOFF/PERMIT sequencer driving the active-low permit and alarm.
module rpsc_interlock_card #(
    parameter int N_FAULT        = 8,
    parameter int FILT_CYCLES    = 4,
    parameter int HOLDOFF_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_FAULT-1:0] fault_in,
    input  logic [N_FAULT-1:0] fault_mask,
    input  logic               clear_req,
    output logic               rf_perm_b,
    output logic               alarm_b,
    output logic [N_FAULT-1:0] fault_latch,
    output logic [N_FAULT-1:0] first_fault,
    output logic [7:0]         trip_count,
    output logic               clear_rej,
    output logic [1:0]         state_o
);

    localparam logic [1:0] ST_PERMIT  = 2'd0;
    localparam logic [1:0] ST_HOLDOFF = 2'd1;
    localparam logic [1:0] ST_TRIPPED = 2'd2;

    localparam logic [7:0]  FILT_MAX = 8'(FILT_CYCLES);
    localparam logic [7:0]  FILT_PRE = 8'(FILT_CYCLES - 1);
    localparam logic [15:0] HOLD_END = 16'(HOLDOFF_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic [7:0]         cnt_q [N_FAULT];
    logic [7:0]         cnt_d [N_FAULT];
    logic [N_FAULT-1:0] latch_q, latch_d;
    logic [N_FAULT-1:0] first_q, first_d;
    logic [7:0]         trip_q, trip_d;
    logic               rf_perm_b_q, rf_perm_b_d;
    logic               alarm_b_q, alarm_b_d;
    logic               clear_rej_q, clear_rej_d;

    logic [N_FAULT-1:0] act;
    logic [N_FAULT-1:0] qual;
    logic               any_qual;
    logic [7:0]         trip_inc;

    assign act = fault_in & ~fault_mask;

    // A channel qualifies only on the edge its counter reaches the filter
    // length; once saturated it stays silent until the input drops.
    always_comb begin
        for (int i = 0; i < N_FAULT; i++) begin
            qual[i]  = act[i] && (cnt_q[i] == FILT_PRE);
            cnt_d[i] = 8'd0;
            if (act[i]) begin
                cnt_d[i] = (cnt_q[i] == FILT_MAX) ? cnt_q[i] : cnt_q[i] + 8'd1;
            end
        end
    end

    assign any_qual = |qual;
    assign trip_inc = (trip_q == 8'hFF) ? trip_q : trip_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        latch_d     = latch_q | qual;
        first_d     = first_q;
        trip_d      = trip_q;
        clear_rej_d = 1'b0;
        case (state_q)
            ST_PERMIT: begin
                if (any_qual) begin
                    state_d = ST_TRIPPED;
                    first_d = qual;
                    trip_d  = trip_inc;
                end
            end
            ST_HOLDOFF: begin
                if (any_qual) begin
                    state_d = ST_TRIPPED;
                    first_d = qual;
                    trip_d  = trip_inc;
                    hold_d  = 16'd0;
                end else if (hold_q == HOLD_END) begin
                    state_d = ST_PERMIT;
                    hold_d  = 16'd0;
                end else begin
                    hold_d = hold_q + 16'd1;
                end
            end
            ST_TRIPPED: begin
                // A qualification implies an active channel, so it also forces a reject.
                if (clear_req) begin
                    if (|act) begin
                        clear_rej_d = 1'b1;
                    end else begin
                        state_d = ST_HOLDOFF;
                        latch_d = '0;
                        first_d = '0;
                        hold_d  = 16'd0;
                    end
                end
            end
            default: begin
                state_d = ST_HOLDOFF;
                hold_d  = 16'd0;
            end
        endcase
        rf_perm_b_d = (state_d != ST_PERMIT);
        alarm_b_d   = ~|latch_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HOLDOFF;
            hold_q      <= 16'd0;
            latch_q     <= '0;
            first_q     <= '0;
            trip_q      <= 8'd0;
            rf_perm_b_q <= 1'b1;
            alarm_b_q   <= 1'b1;
            clear_rej_q <= 1'b0;
            for (int i = 0; i < N_FAULT; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            latch_q     <= latch_d;
            first_q     <= first_d;
            trip_q      <= trip_d;
            rf_perm_b_q <= rf_perm_b_d;
            alarm_b_q   <= alarm_b_d;
            clear_rej_q <= clear_rej_d;
            for (int i = 0; i < N_FAULT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rf_perm_b   = rf_perm_b_q;
    assign alarm_b     = alarm_b_q;
    assign fault_latch = latch_q;
    assign first_fault = first_q;
    assign trip_count  = trip_q;
    assign clear_rej   = clear_rej_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_rpsc_interlock_card.sv
// Directed bench for rpsc_interlock_card: the driver queues the expected output
// values for each edge, and a monitor pops and compares them one cycle later.
module tb_rpsc_interlock_card;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] fault_in;
    logic [7:0] fault_mask;
    logic       clear_req;
    logic       rf_perm_b;
    logic       alarm_b;
    logic [7:0] fault_latch;
    logic [7:0] first_fault;
    logic [7:0] trip_count;
    logic       clear_rej;
    logic [1:0] state_o;

    localparam logic [7:0] F_RF = 0, F_AL = 1, F_LA = 2, F_FF = 3, F_TC = 4, F_RJ = 5;

    // Entry layout: {edge tag[47:16], field[15:8], expected value[7:0]}
    logic [47:0] exp_q[$];
    int          cyc     = 0;
    int          n_check = 0;
    int          n_fail  = 0;

    rpsc_interlock_card #(
        .N_FAULT(8),
        .FILT_CYCLES(4),
        .HOLDOFF_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fault_in(fault_in),
        .fault_mask(fault_mask),
        .clear_req(clear_req),
        .rf_perm_b(rf_perm_b),
        .alarm_b(alarm_b),
        .fault_latch(fault_latch),
        .first_fault(first_fault),
        .trip_count(trip_count),
        .clear_rej(clear_rej),
        .state_o(state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    function automatic string fname(input logic [7:0] f);
        case (f)
            F_RF:    return "rf_perm_b";
            F_AL:    return "alarm_b";
            F_LA:    return "fault_latch";
            F_FF:    return "first_fault";
            F_TC:    return "trip_count";
            default: return "clear_rej";
        endcase
    endfunction

    function automatic void compare(input logic [7:0] f, input logic [7:0] want, input string ctx);
        logic [7:0] got;
        case (f)
            F_RF:    got = {7'd0, rf_perm_b};
            F_AL:    got = {7'd0, alarm_b};
            F_LA:    got = fault_latch;
            F_FF:    got = first_fault;
            F_TC:    got = trip_count;
            default: got = {7'd0, clear_rej};
        endcase
        n_check++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s %s edge=%0d state=%0d actual=%0h expected=%0h",
                     ctx, fname(f), cyc, state_o, got, want);
        end
    endfunction

    // scoreboard monitor
    initial begin
        logic [47:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0 && int'(exp_q[0][47:16]) <= cyc) begin
                e = exp_q.pop_front();
                compare(e[15:8], e[7:0], "edge");
            end
        end
    end

    // driver tasks
    function automatic void exp_next(input logic [7:0] f, input logic [7:0] v);
        exp_q.push_back({32'(cyc + 1), f, v});
    endfunction

    function automatic void exp_all(input logic rf, input logic al, input logic [7:0] la,
                                    input logic [7:0] ff, input logic [7:0] tc, input logic rj);
        exp_next(F_RF, {7'd0, rf});
        exp_next(F_AL, {7'd0, al});
        exp_next(F_LA, la);
        exp_next(F_FF, ff);
        exp_next(F_TC, tc);
        exp_next(F_RJ, {7'd0, rj});
    endfunction

    task automatic tick(input logic [7:0] f, input logic [7:0] m, input logic c);
        @(negedge clk);
        fault_in   = f;
        fault_mask = m;
        clear_req  = c;
    endtask

    initial begin
        int tc_exp;
        reset      = 1'b1;
        fault_in   = '0;
        fault_mask = '0;
        clear_req  = 1'b0;

        // 1. reset, then 16 edges of HOLDOFF before permit
        tick(8'h00, 8'h00, 1'b0);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            tick(8'h00, 8'h00, 1'b0);
            exp_next(F_RF, (k < 16) ? 8'd1 : 8'd0);
            exp_next(F_AL, 8'd1);
        end

        // 2. glitch of 3 cycles is filtered, 4 cycles trips
        for (int k = 0; k < 3; k++) begin
            tick(8'h08, 8'h00, 1'b0);
            exp_next(F_RF, 8'd0);
        end
        tick(8'h00, 8'h00, 1'b0);
        exp_all(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick(8'h08, 8'h00, 1'b0);
            exp_next(F_RF, 8'd0);
        end
        tick(8'h08, 8'h00, 1'b0);
        exp_all(1'b1, 1'b0, 8'h08, 8'h08, 8'd1, 1'b0);
        tick(8'h00, 8'h00, 1'b0);

        // 3. clear, then simultaneous faults 0 and 5, later fault 7
        tick(8'h00, 8'h00, 1'b1);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd1, 1'b0);
        for (int k = 0; k < 3; k++) tick(8'h21, 8'h00, 1'b0);
        tick(8'h21, 8'h00, 1'b0);
        exp_all(1'b1, 1'b0, 8'h21, 8'h21, 8'd2, 1'b0);
        for (int k = 0; k < 3; k++) tick(8'hA1, 8'h00, 1'b0);
        tick(8'hA1, 8'h00, 1'b0);
        exp_all(1'b1, 1'b0, 8'hA1, 8'h21, 8'd2, 1'b0);

        // 4. clear refused while channel 5 active, accepted once quiet
        tick(8'h20, 8'h00, 1'b1);
        exp_all(1'b1, 1'b0, 8'hA1, 8'h21, 8'd2, 1'b1);
        tick(8'h20, 8'h00, 1'b0);
        exp_next(F_RJ, 8'd0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd2, 1'b0);
        for (int j = 1; j <= 16; j++) begin
            tick(8'h00, 8'h00, 1'b0);
            exp_next(F_RF, (j < 16) ? 8'd1 : 8'd0);
        end
        tick(8'h00, 8'h00, 1'b1);
        exp_all(1'b0, 1'b1, 8'h00, 8'h00, 8'd2, 1'b0);

        // 5. trip from PERMIT, clear, then trip at holdoff count 10
        for (int k = 0; k < 4; k++) tick(8'h01, 8'h00, 1'b0);
        exp_all(1'b1, 1'b0, 8'h01, 8'h01, 8'd3, 1'b0);
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        for (int j = 1; j <= 11; j++) begin
            tick((j >= 8) ? 8'h02 : 8'h00, 8'h00, 1'b0);
            if (j == 10) exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd3, 1'b0);
            if (j == 11) exp_all(1'b1, 1'b0, 8'h02, 8'h02, 8'd4, 1'b0);
        end
        tick(8'h00, 8'h00, 1'b0);
        tick(8'h00, 8'h00, 1'b1);
        // masked channel held high must not trip; permit still granted
        for (int j = 1; j <= 20; j++) begin
            tick(8'h04, 8'h04, 1'b0);
            if (j == 16 || j == 20) exp_all(1'b0, 1'b1, 8'h00, 8'h00, 8'd4, 1'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            tick(8'h04, 8'h00, 1'b0);
            if (k == 3) exp_next(F_RF, 8'd0);
        end
        exp_all(1'b1, 1'b0, 8'h04, 8'h04, 8'd5, 1'b0);
        tick(8'h04, 8'h04, 1'b0);
        exp_all(1'b1, 1'b0, 8'h04, 8'h04, 8'd5, 1'b0);
        tick(8'h04, 8'h04, 1'b1);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd5, 1'b0);
        tick(8'h00, 8'h00, 1'b0);

        // 6. repeated trip/clear until the counter saturates
        for (int k = 1; k <= 260; k++) begin
            for (int j = 0; j < 4; j++) tick(8'h01, 8'h00, 1'b0);
            tc_exp = (5 + k > 255) ? 255 : 5 + k;
            exp_next(F_TC, 8'(tc_exp));
            exp_next(F_RF, 8'd1);
            tick(8'h00, 8'h00, 1'b1);
            exp_next(F_LA, 8'h00);
        end
        tick(8'h00, 8'h00, 1'b0);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd255, 1'b0);
        tick(8'h00, 8'h00, 1'b0);

        // asynchronous reset mid-HOLDOFF, checked between edges
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare(F_RF, 8'd1, "async");
        compare(F_AL, 8'd1, "async");
        compare(F_LA, 8'h00, "async");
        compare(F_FF, 8'h00, "async");
        compare(F_TC, 8'd0, "async");
        compare(F_RJ, 8'd0, "async");
        @(negedge clk);
        reset = 1'b0;
        tick(8'h00, 8'h00, 1'b0);
        exp_all(1'b1, 1'b1, 8'h00, 8'h00, 8'd0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        n_check++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
